// File: rtl/chunked_adder_seq.sv
// Multi-cycle add/sub: CHUNK bits per clock with a registered carry; optional clamp via `CHUNKED_ADDER_SAT_EN.
// Latency NCHUNK cycles accept-to-done; one result per NCHUNK+1 cycles with start held.
// Backpressure: start is only sampled in IDLE/DONE; requests while busy are dropped, never queued.
module chunked_adder_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] shadow;
    logic             carry;
    logic [KW-1:0]    k;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] sum_c;
    logic             c_out;
    logic             c_msb;
    logic             ovf_n;
    logic [WIDTH-1:0] shadow_n;
    logic [WIDTH-1:0] s_n;

    // Operand registers shift right each RUN cycle, so the active chunk is
    // always the low slice; the shadow fills from the top in the same way.
    always_comb begin
        a_c = a_r[CHUNK-1:0];
        b_c = b_r[CHUNK-1:0];
        {c_out, sum_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
        c_msb = sum_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
        ovf_n = c_msb ^ c_out;
        shadow_n = (shadow >> CHUNK) | (WIDTH'(sum_c) << (WIDTH - CHUNK));
        s_n = shadow_n;
`ifdef CHUNKED_ADDER_SAT_EN
        // In the last chunk a_c's MSB is the operand sign; on overflow both signs agree.
        if (ovf_n) begin
            s_n = a_c[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            s      <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b ^ {WIDTH{sub}};
                        carry <= cin ^ sub;
                        k     <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    a_r    <= a_r >> CHUNK;
                    b_r    <= b_r >> CHUNK;
                    shadow <= shadow_n;
                    carry  <= c_out;
                    if (k == KLAST) begin
                        k     <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= s_n;
                        cout  <= c_out;
                        ovf   <= ovf_n;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_adder_seq.sv
// Self-checking bench: 16/4 and 8/8 instances checked against an arithmetic reference model.
module tb_chunked_adder_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, ovf;
    logic [15:0] s;
    logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  s8;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] last_s = '0;

    always #5 clk = ~clk;

    chunked_adder_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf));

    chunked_adder_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8));

    // Reference: whole-word two's-complement arithmetic on w bits.
    function automatic void model(input int w, input logic [31:0] ia, ib, input logic icin, isub,
                                  output logic [31:0] rs, output logic rco, rov);
        logic [32:0] mask, full;
        logic [31:0] bb;
        mask = (33'd1 << w) - 33'd1;
        bb   = isub ? (~ib & mask[31:0]) : ib;
        full = {1'b0, ia} + {1'b0, bb} + 33'(icin ^ isub);
        rco  = full[w];
        rs   = full[31:0] & mask[31:0];
        rov  = (ia[w-1] == bb[w-1]) && (rs[w-1] != ia[w-1]);
`ifdef CHUNKED_ADDER_SAT_EN
        if (rov) rs = ia[w-1] ? (32'd1 << (w-1)) : ((32'd1 << (w-1)) - 32'd1);
`endif
    endfunction

    task automatic go16(input logic [15:0] ia, ib, input logic icin, isub);
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait16(output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!done && n < 40);
    endtask

    task automatic go8(input logic [7:0] ia, ib, input logic icin, isub);
        a8 = ia; b8 = ib; cin8 = icin; sub8 = isub; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait8(output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!done8 && n < 40);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if ({s, cout, ovf} !== 18'h0) begin n_err++; $display("FAIL reset_outs got s=%h c=%b o=%b want 0", s, cout, ovf); end
        n_cmp++; if ({busy8, done8, s8, cout8, ovf8} !== 12'h0) begin n_err++; $display("FAIL reset_dut8 got s=%h want 0", s8); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [15:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] tb [5] = '{16'h1111, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] es;
        logic        ec, eo;
        int n;
        for (int i = 0; i < 5; i++) begin
            go16(ta[i], tb[i], 1'b0, ts[i]);
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy_after_accept got %b want 1", i, busy); end
            wait16(n);
            model(16, 32'(ta[i]), 32'(tb[i]), 1'b0, ts[i], es, ec, eo);
            n_cmp++; if (n !== 4 || done !== 1'b1) begin n_err++; $display("FAIL dir%0d_latency got %0d done=%b want 4", i, n, done); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_at_done got %b want 0", i, busy); end
            n_cmp++; if ({s, cout, ovf} !== {es[15:0], ec, eo}) begin
                n_err++; $display("FAIL dir%0d_result got s=%h c=%b o=%b want s=%h c=%b o=%b", i, s, cout, ovf, es[15:0], ec, eo);
            end
            last_s = es[15:0];
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse got %b want 0", i, done); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] es;
        logic        ec, eo;
        int n1, n2;
        a = 16'h0005; b = 16'h0007; cin = 1'b0; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h0007; b = 16'h0005;
        wait16(n1);
        model(16, 32'h5, 32'h7, 1'b0, 1'b1, es, ec, eo);
        n_cmp++; if (n1 !== 4) begin n_err++; $display("FAIL b2b_first_latency got %0d want 4", n1); end
        n_cmp++; if ({s, cout, ovf} !== {es[15:0], ec, eo}) begin
            n_err++; $display("FAIL b2b_first got s=%h c=%b o=%b want s=%h c=%b o=%b", s, cout, ovf, es[15:0], ec, eo);
        end
        wait16(n2);
        start = 1'b0;
        model(16, 32'h7, 32'h5, 1'b0, 1'b1, es, ec, eo);
        n_cmp++; if (n2 !== 5 || done !== 1'b1) begin n_err++; $display("FAIL b2b_spacing got %0d want 5", n2); end
        n_cmp++; if ({s, cout, ovf} !== {es[15:0], ec, eo}) begin
            n_err++; $display("FAIL b2b_second got s=%h c=%b o=%b want s=%h c=%b o=%b", s, cout, ovf, es[15:0], ec, eo);
        end
        last_s = es[15:0];
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run;
        int ndone = 0;
        go16(16'h4321, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if ({s, cout, ovf} !== 18'h0) begin n_err++; $display("FAIL midrst_outs got s=%h c=%b o=%b want 0", s, cout, ovf); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
        last_s = '0;
    endtask

    task automatic test_busy_ignore;
        logic [31:0] es;
        logic        ec, eo;
        logic [15:0] s_at_done = '0;
        int ndone = 0, nhold_bad = 0;
        go16(16'h0F0F, 16'h3003, 1'b1, 1'b0);
        model(16, 32'h0F0F, 32'h3003, 1'b1, 1'b0, es, ec, eo);
        for (int i = 0; i < 12; i++) begin
            if (i < 3) begin a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); start = 1'b1; end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy && s !== last_s) nhold_bad++;
            if (done) begin ndone++; s_at_done = s; end
        end
        n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        n_cmp++; if (s_at_done !== es[15:0]) begin n_err++; $display("FAIL ignore_result got %h want %h", s_at_done, es[15:0]); end
        n_cmp++; if (nhold_bad !== 0) begin n_err++; $display("FAIL ignore_s_hold got %0d changes want 0", nhold_bad); end
        last_s = es[15:0];
    endtask

    task automatic test_random;
        logic [15:0] ra, rb;
        logic        rc, rsb;
        logic [31:0] es;
        logic        ec, eo;
        int n, bad = 0;
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rsb = 1'($urandom);
            if (i % 7 == 0) ra = {ra[15], {15{~ra[15]}}};
            go16(ra, rb, rc, rsb);
            wait16(n);
            model(16, 32'(ra), 32'(rb), rc, rsb, es, ec, eo);
            n_cmp++; if (n !== 4 || {s, cout, ovf} !== {es[15:0], ec, eo}) begin
                n_err++;
                if (bad++ < 5) $display("FAIL rand_op a=%h b=%h cin=%b sub=%b got s=%h c=%b o=%b n=%0d want s=%h c=%b o=%b n=4",
                                        ra, rb, rc, rsb, s, cout, ovf, n, es[15:0], ec, eo);
            end
            last_s = es[15:0];
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single_chunk;
        logic [7:0]  ra, rb;
        logic        rc, rsb;
        logic [31:0] es;
        logic        ec, eo;
        int n;
        go8(8'h80, 8'h80, 1'b0, 1'b0);
        wait8(n);
        model(8, 32'h80, 32'h80, 1'b0, 1'b0, es, ec, eo);
        n_cmp++; if (n !== 1 || done8 !== 1'b1) begin n_err++; $display("FAIL w8_latency got %0d want 1", n); end
        n_cmp++; if ({s8, cout8, ovf8} !== {es[7:0], ec, eo}) begin
            n_err++; $display("FAIL w8_0x80 got s=%h c=%b o=%b want s=%h c=%b o=%b", s8, cout8, ovf8, es[7:0], ec, eo);
        end
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rsb = 1'($urandom);
            go8(ra, rb, rc, rsb);
            wait8(n);
            model(8, 32'(ra), 32'(rb), rc, rsb, es, ec, eo);
            n_cmp++; if (n !== 1 || {s8, cout8, ovf8} !== {es[7:0], ec, eo}) begin
                n_err++; $display("FAIL w8_rand a=%h b=%h got s=%h c=%b o=%b want s=%h c=%b o=%b", ra, rb, s8, cout8, ovf8, es[7:0], ec, eo);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_mid_run;
        test_busy_ignore;
        test_random;
        test_single_chunk;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/chunked_adder_seq.md
# chunked_adder_seq

Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks through a registered carry, so a wide add costs WIDTH/CHUNK cycles of a narrow ripple slice instead of one long combinational carry chain. It sits in the arithmetic datapath as a start/done-handshaked unit. It extends the combinational 4-bit ripple adder with:
- width and chunk generalisation
- add/subtract mode
- a signed-overflow flag
- optional saturation

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  operand A, latched on accepted start.
- b  input  WIDTH  operand B, latched on accepted start.
- cin  input  1  carry-in (borrow-in when sub=1), latched on accepted start.
- sub  input  1  mode: 0 = add, 1 = subtract; latched on accepted start.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse; result outputs are valid.
- s  output  WIDTH  result.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operand and carry, fixed at accept:
  - b_eff = b XOR {WIDTH{sub}}.
  - c_in_eff = cin XOR sub.
  - sub=1, cin=0 gives a−b; sub=1, cin=1 gives a−b−1.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE→RUN on start; latches a, b_eff, c_in_eff; chunk index k=0.
  - RUN: each cycle adds chunk k, i.e. bits [k*CHUNK +: CHUNK], plus the carry register. The sum goes to an internal shadow register and the carry register takes the chunk carry-out; then k increments.
  - RUN→DONE after chunk NCHUNK−1.
  - DONE→RUN if start is high, accepting new operands (back-to-back).
  - DONE→IDLE otherwise.
- start during RUN is ignored; no queuing.
- s, cout and ovf update only on the RUN→DONE edge. They hold the previous result through any later RUN and until the next DONE.
- Arithmetic is modulo 2^WIDTH. cout is the final chunk carry.
- ovf = carry into MSB XOR carry out of MSB, computed inside the last chunk.
- Reset: state IDLE, k=0, carry register 0, shadow 0. Outputs busy=0, done=0, s=0, cout=0, ovf=0.
- Reset asserted mid-RUN aborts the operation. No done is produced and outputs return to 0.
- WIDTH==CHUNK is legal: a single RUN cycle.

## Timing
- Accept edge E0: start is high while the state is IDLE or DONE.
- RUN occupies edges E1..E(NCHUNK). The state enters DONE at edge E(NCHUNK).
- done and the valid result are visible in the cycle after E(NCHUNK): latency is NCHUNK cycles from accept to done.
- Throughput is one result per NCHUNK+1 cycles with start held high.
- busy rises the cycle after E0 and falls in the same cycle done rises.
- Default parameters: 4-cycle latency, 5-cycle throughput.

## Configuration
- Macro `CHUNKED_ADDER_SAT_EN`.
- Defined: when ovf=1, s is clamped to the signed extreme instead of the wrapped sum.
  - Positive overflow (MSB of a and b_eff both 0) gives 0111…1.
  - Negative overflow gives 1000…0.
  - cout and ovf are reported unchanged.
- Undefined: s is always the wrapped modulo-2^WIDTH sum. No clamp logic is present.

## Test plan
Scenarios 1–5 use WIDTH=16, CHUNK=4.
1. a=0x1234, b=0x1111, cin=0, sub=0, start for one cycle -> busy for 4 cycles; then done=1 for one cycle with s=0x2345, cout=0, ovf=0.
2. a=0xFFFF, b=0x0001, add -> s=0x0000, cout=1, ovf=0 (carry ripples through all chunks).
3. a=0x7FFF, b=0x0001, add -> ovf=1, cout=0.
   - s=0x8000 without `CHUNKED_ADDER_SAT_EN`.
   - s=0x7FFF with it.
4. Subtract and back-to-back:
   - a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0, ovf=0.
   - Hold start with a new operand pair (0x0007−0x0005) -> second done exactly 5 cycles after the first, with s=0x0002 and cout=1.
5. Busy and reset behaviour:
   - start pulses during RUN are ignored: exactly one done, and the result matches the first operands.
   - rst asserted on the 2nd RUN cycle -> next cycle busy=0, s=0, and no done follows.
6. WIDTH=8, CHUNK=8, a=0x80, b=0x80, add -> done one cycle after accept; s=0x00, cout=1, ovf=1 (s=0x80 with SAT_EN).
